fire_nozzle_dispatcher: RTL

Downstream consumer of the priority matrix checker. It accepts the checker's priority-ordered target pair (point 1 first, optional point 2) through a valid/ready handshake. It then steps the extinguisher nozzle cell by cell to each target, sprays for a fixed time at each one, and returns the nozzle to home (0,0). It owns the nozzle position register and the spray valve enable for the grid actuator.

---
 rtl/fire_nozzle_dispatcher_if.sv | 26 ++
 rtl/fire_nozzle_dispatcher.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fire_nozzle_dispatcher_if.sv
// Target-pair handshake between the priority matrix checker (master) and
// the nozzle dispatcher (slave).
interface fire_nozzle_dispatcher_if #(
    parameter int COORD_W = 2
);
    // A pair transfers on a rising clk edge where tgt_valid && tgt_ready.
    // The master holds the points and point2_en stable while tgt_valid is
    // high. tgt_ready never depends combinationally on tgt_valid.
    logic               tgt_valid;
    logic               tgt_ready;
    logic [COORD_W-1:0] point1_x;
    logic [COORD_W-1:0] point1_y;
    logic [COORD_W-1:0] point2_x;
    logic [COORD_W-1:0] point2_y;
    logic               point2_en;

    modport master (
        output tgt_valid, point1_x, point1_y, point2_x, point2_y, point2_en,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid, point1_x, point1_y, point2_x, point2_y, point2_en,
        output tgt_ready
    );
endinterface

// File: rtl/fire_nozzle_dispatcher.sv
// Steps the extinguisher nozzle to one or two targets, sprays each one for a
// fixed time, then returns the nozzle home to (0,0).
module fire_nozzle_dispatcher #(
    parameter int COORD_W      = 2,
    parameter int STEP_CYCLES  = 4,
    parameter int SPRAY_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    fire_nozzle_dispatcher_if.slave  tgt,
    input  logic                     abort,
    output logic [COORD_W-1:0]       pos_x,
    output logic [COORD_W-1:0]       pos_y,
    output logic                     moving,
    output logic                     spray_on,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               state_dbg
);

    localparam int STEP_W  = (STEP_CYCLES  > 1) ? $clog2(STEP_CYCLES)  : 1;
    localparam int SPRAY_W = (SPRAY_CYCLES > 1) ? $clog2(SPRAY_CYCLES) : 1;
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_CYCLES - 1);
    localparam logic [SPRAY_W-1:0] SPRAY_LAST = SPRAY_W'(SPRAY_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        SPRAY = 2'd2,
        HOME  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [COORD_W-1:0]   p1_x_q, p1_x_d, p1_y_q, p1_y_d;
    logic [COORD_W-1:0]   p2_x_q, p2_x_d, p2_y_q, p2_y_d;
    logic                 p2_en_q, p2_en_d;
    logic                 leg_q, leg_d;
    logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
    logic [SPRAY_W-1:0]   spray_cnt_q, spray_cnt_d;
    logic                 done_q, done_d;

    logic [COORD_W-1:0]   dest_x, dest_y;
    logic                 at_dest;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            p1_x_q      <= '0;
            p1_y_q      <= '0;
            p2_x_q      <= '0;
            p2_y_q      <= '0;
            p2_en_q     <= 1'b0;
            leg_q       <= 1'b0;
            step_cnt_q  <= '0;
            spray_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            p1_x_q      <= p1_x_d;
            p1_y_q      <= p1_y_d;
            p2_x_q      <= p2_x_d;
            p2_y_q      <= p2_y_d;
            p2_en_q     <= p2_en_d;
            leg_q       <= leg_d;
            step_cnt_q  <= step_cnt_d;
            spray_cnt_q <= spray_cnt_d;
            done_q      <= done_d;
        end
    end

    // HOME always heads for the origin; MOVE heads for the current leg's target.
    always_comb begin
        dest_x = '0;
        dest_y = '0;
        if (state_q == MOVE) begin
            dest_x = leg_q ? p2_x_q : p1_x_q;
            dest_y = leg_q ? p2_y_q : p1_y_q;
        end
        at_dest = (pos_x_q == dest_x) && (pos_y_q == dest_y);
    end

    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        p1_x_d      = p1_x_q;
        p1_y_d      = p1_y_q;
        p2_x_d      = p2_x_q;
        p2_y_d      = p2_y_q;
        p2_en_d     = p2_en_q;
        leg_d       = leg_q;
        step_cnt_d  = step_cnt_q;
        spray_cnt_d = spray_cnt_q;

        case (state_q)
            IDLE: begin
                if (tgt.tgt_valid) begin
                    p1_x_d     = tgt.point1_x;
                    p1_y_d     = tgt.point1_y;
                    p2_x_d     = tgt.point2_x;
                    p2_y_d     = tgt.point2_y;
                    p2_en_d    = tgt.point2_en;
                    leg_d      = 1'b0;
                    step_cnt_d = '0;
                    state_d    = MOVE;
                end
            end
            MOVE, HOME: begin
                if (state_q == MOVE && abort) begin
                    state_d     = HOME;
                    step_cnt_d  = '0;
                    spray_cnt_d = '0;
                end else if (at_dest) begin
                    state_d     = (state_q == MOVE) ? SPRAY : IDLE;
                    step_cnt_d  = '0;
                    spray_cnt_d = '0;
                end else if (step_cnt_q == STEP_LAST) begin
                    step_cnt_d = '0;
                    // x is corrected first; y only moves once x matches.
                    if (pos_x_q != dest_x) begin
                        pos_x_d = (dest_x > pos_x_q) ? pos_x_q + COORD_W'(1)
                                                     : pos_x_q - COORD_W'(1);
                    end else begin
                        pos_y_d = (dest_y > pos_y_q) ? pos_y_q + COORD_W'(1)
                                                     : pos_y_q - COORD_W'(1);
                    end
                end else begin
                    step_cnt_d = step_cnt_q + STEP_W'(1);
                end
            end
            SPRAY: begin
                if (abort) begin
                    state_d     = HOME;
                    step_cnt_d  = '0;
                    spray_cnt_d = '0;
                end else if (spray_cnt_q == SPRAY_LAST) begin
                    spray_cnt_d = '0;
                    step_cnt_d  = '0;
                    if (!leg_q && p2_en_q) begin
                        leg_d   = 1'b1;
                        state_d = MOVE;
                    end else begin
                        state_d = HOME;
                    end
                end else begin
                    spray_cnt_d = spray_cnt_q + SPRAY_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_d = (state_q == HOME) && (state_d == IDLE);

    assign tgt.tgt_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign moving        = (state_q == MOVE) || (state_q == HOME);
    assign spray_on      = (state_q == SPRAY);
    assign pos_x         = pos_x_q;
    assign pos_y         = pos_y_q;
    assign done          = done_q;
    assign state_dbg     = state_q;

endmodule
